// File: rtl/lms_coef_update.sv
// LMS coefficient updater: holds a sample history, snapshots it together with
// the error on each accepted request, then walks the taps one per cycle.
module lms_coef_update #(
    parameter int NTAPS    = 15,
    parameter int MU_SHIFT = 8,
    parameter int CENTER   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       xn,
    input  logic              sample_valid,
    input  logic [15:0]       err,
    input  logic              err_valid,
    input  logic              freeze,
    input  logic              load_en,
    input  logic [3:0]        load_idx,
    input  logic [15:0]       load_data,
    output logic [15:0][15:0] coef,
    output logic              busy,
    output logic              upd_done,
    output logic              err_drop,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

    localparam logic [3:0] LAST_IDX = 4'(NTAPS - 1);
    localparam logic [4:0] NTAPS_W  = 5'(NTAPS);

    state_t             state;
    state_t             state_next;
    logic [3:0]         idx;
    logic [15:0]        hist      [NTAPS];
    logic [15:0]        hist_snap [NTAPS];
    logic [15:0]        err_snap;
    logic [15:0]        coef_r    [NTAPS];
    logic               accept;
    logic               load_ok;
    logic signed [31:0] prod;
    logic signed [16:0] delta;
    logic signed [16:0] sum;
    logic [15:0]        upd_val;

    // Next-state, acceptance and drop decisions.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        err_drop   = busy & err_valid & ~freeze;
        load_ok    = load_en && (state == S_IDLE) && ({1'b0, load_idx} < NTAPS_W);
        case (state)
            S_IDLE: begin
                if (err_valid && !freeze) begin
                    state_next = S_UPDATE;
                    accept     = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_UPDATE: begin
                if (idx == LAST_IDX) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_UPDATE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register; busy/upd_done are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            upd_done <= 1'b0;
            idx      <= 4'd0;
        end else begin
            state    <= state_next;
            busy     <= (state_next != S_IDLE);
            upd_done <= (state_next == S_DONE);
            if (state == S_UPDATE) begin
                idx <= idx + 4'd1;
            end else begin
                idx <= 4'd0;
            end
        end
    end

    // Sample history keeps shifting independent of the update in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) hist[i] <= 16'h0000;
        end else if (sample_valid) begin
            hist[0] <= xn;
            for (int i = 1; i < NTAPS; i++) hist[i] <= hist[i-1];
        end
    end

    // Snapshot of error and history taken at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_snap <= 16'h0000;
            for (int i = 0; i < NTAPS; i++) hist_snap[i] <= 16'h0000;
        end else if (accept) begin
            err_snap <= err;
            for (int i = 0; i < NTAPS; i++) hist_snap[i] <= hist[i];
        end
    end

    // Per-tap update value: floor-shifted product added with 16-bit saturation.
    always_comb begin
        prod  = 32'($signed(err_snap)) * 32'($signed(hist_snap[idx]));
        delta = 17'(prod >>> (15 + MU_SHIFT));
        sum   = $signed({coef_r[idx][15], coef_r[idx]}) + delta;
        if (sum[16] != sum[15]) begin
            upd_val = sum[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            upd_val = sum[15:0];
        end
    end

    // Coefficient storage: loads only in IDLE (before any update reads them).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                coef_r[i] <= (i == CENTER) ? 16'h7FFF : 16'h0000;
            end
        end else if (load_ok) begin
            coef_r[load_idx] <= load_data;
        end else if (state == S_UPDATE) begin
            coef_r[idx] <= upd_val;
        end
    end

    // Saturating counter of rejected requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (err_drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Unused top entries of the coefficient bus are tied to zero.
    always_comb begin
        coef = '0;
        for (int i = 0; i < NTAPS; i++) coef[i] = coef_r[i];
    end

endmodule

// File: tb/tb_lms_coef_update.sv
// Directed bench for lms_coef_update: table of full-history updates plus
// hand-written sequences for latency, drops, freeze, loads and mid-update reset.
module tb_lms_coef_update;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       xn;
    logic              sample_valid;
    logic [15:0]       err;
    logic              err_valid;
    logic              freeze;
    logic              load_en;
    logic [3:0]        load_idx;
    logic [15:0]       load_data;
    logic [15:0][15:0] coef;
    logic              busy;
    logic              upd_done;
    logic              err_drop;
    logic [7:0]        drop_cnt;

    int checks = 0;
    int errors = 0;

    lms_coef_update dut (
        .clk(clk), .rst(rst), .xn(xn), .sample_valid(sample_valid),
        .err(err), .err_valid(err_valid), .freeze(freeze),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
        .coef(coef), .busy(busy), .upd_done(upd_done),
        .err_drop(err_drop), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] samp;
        logic [15:0] err;
        logic        ld;
        logic [15:0] ld_data;
        logic [15:0] exp_tap;
        logic [15:0] exp_c0;
        logic [15:0] exp_c7;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_samples(input logic [15:0] v);
        sample_valid = 1'b1;
        xn = v;
        for (int i = 0; i < 15; i++) step();
        sample_valid = 1'b0;
    endtask

    // Returns the cycle index (1 = cycle after acceptance edge) at which upd_done is seen, -1 on timeout.
    task automatic wait_done(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            if (upd_done) begin
                n = k;
                break;
            end
            step();
        end
    endtask

    task automatic accept_update(input logic [15:0] e);
        err = e;
        err_valid = 1'b1;
        step();
        err_valid = 1'b0;
    endtask

    initial begin
        int n;
        int busy_cycles;
        int drops;
        int done_at;
        int done_pulses;

        rst = 1'b1; xn = '0; sample_valid = 1'b0; err = '0; err_valid = 1'b0;
        freeze = 1'b0; load_en = 1'b0; load_idx = '0; load_data = '0;

        vecs[0] = '{16'h4000, 16'h4000, 1'b0, 16'h0000, 16'h0020, 16'h0020, 16'h7FFF};
        vecs[1] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0000, 16'hFF80, 16'hFF80, 16'h7F7F};
        vecs[2] = '{16'h8000, 16'h7FFF, 1'b1, 16'h8010, 16'hFF80, 16'h8000, 16'h7F7F};
        vecs[3] = '{16'hC000, 16'h4000, 1'b0, 16'h0000, 16'hFFE0, 16'hFFE0, 16'h7FDF};
        vecs[4] = '{16'h0100, 16'h0100, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF};
        vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h7FFE};

        do_reset();
        chk("reset_c7", coef[7], 16'h7FFF);
        chk("reset_c0", coef[0], 16'h0000);
        chk("reset_c14", coef[14], 16'h0000);
        chk("reset_c15", coef[15], 16'h0000);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", upd_done, 1'b0);
        chk("reset_drop", err_drop, 1'b0);
        chk("reset_dcnt", drop_cnt, 8'd0);

        // Table of full updates; optional load of coef[0] in the acceptance cycle.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            push_samples(vecs[v].samp);
            load_en = vecs[v].ld;
            load_idx = 4'd0;
            load_data = vecs[v].ld_data;
            accept_update(vecs[v].err);
            load_en = 1'b0;
            wait_done(n);
            chk($sformatf("v%0d_latency", v), n, 16);
            chk($sformatf("v%0d_c0", v), coef[0], vecs[v].exp_c0);
            chk($sformatf("v%0d_c3", v), coef[3], vecs[v].exp_tap);
            chk($sformatf("v%0d_c7", v), coef[7], vecs[v].exp_c7);
            chk($sformatf("v%0d_c14", v), coef[14], vecs[v].exp_tap);
            chk($sformatf("v%0d_c15", v), coef[15], 16'h0000);
            step();
            chk($sformatf("v%0d_idle", v), busy, 1'b0);
        end

        // Busy window, single done pulse, three drops, freeze during busy.
        do_reset();
        accept_update(16'h0000);
        busy_cycles = 0; drops = 0; done_at = -1; done_pulses = 0;
        for (int k = 1; k <= 24; k++) begin
            if (busy) busy_cycles++;
            if (upd_done) begin
                done_pulses++;
                if (done_at < 0) done_at = k;
            end
            err_valid = (k == 3 || k == 6 || k == 9 || k == 11);
            freeze = (k == 11);
            #1;
            if (err_drop) drops++;
            step();
            err_valid = 1'b0;
            freeze = 1'b0;
        end
        chk("busy_cycles", busy_cycles, 16);
        chk("done_at", done_at, 16);
        chk("done_pulses", done_pulses, 1);
        chk("drop_pulses", drops, 3);
        chk("drop_cnt3", drop_cnt, 8'd3);

        // Freeze in IDLE: no acceptance, no drop.
        freeze = 1'b1;
        err_valid = 1'b1;
        #1;
        chk("freeze_nodrop", err_drop, 1'b0);
        step();
        err_valid = 1'b0;
        freeze = 1'b0;
        chk("freeze_idle", busy, 1'b0);
        chk("freeze_dcnt", drop_cnt, 8'd3);

        // Loads: idx 15 ignored, valid idx applied, load while busy ignored.
        load_en = 1'b1; load_idx = 4'd15; load_data = 16'h1234;
        step();
        load_idx = 4'd14;
        step();
        load_en = 1'b0;
        chk("load_c15", coef[15], 16'h0000);
        chk("load_c14", coef[14], 16'h1234);
        accept_update(16'h0000);
        load_en = 1'b1; load_idx = 4'd2; load_data = 16'h5555;
        step();
        load_en = 1'b0;
        wait_done(n);
        step();
        chk("load_busy_c2", coef[2], 16'h0000);

        // 320 drops saturate the counter at 255.
        do_reset();
        err = 16'h0000;
        drops = 0;
        err_valid = 1'b1;
        for (int k = 0; k < 340; k++) begin
            #1;
            if (err_drop) drops++;
            step();
        end
        err_valid = 1'b0;
        chk("drop_pulses320", drops, 320);
        chk("drop_cnt_sat", drop_cnt, 8'd255);
        wait_done(n);
        step();

        // Reset when tap 5 is about to be written.
        do_reset();
        push_samples(16'h4000);
        accept_update(16'h4000);
        for (int k = 0; k < 5; k++) step();
        chk("mid_c4_written", coef[4], 16'h0020);
        chk("mid_c5_pending", coef[5], 16'h0000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_c4", coef[4], 16'h0000);
        chk("mid_rst_c0", coef[0], 16'h0000);
        chk("mid_rst_c7", coef[7], 16'h7FFF);
        chk("mid_rst_busy", busy, 1'b0);
        done_pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (upd_done) done_pulses++;
            step();
        end
        chk("mid_rst_nodone", done_pulses, 0);

        // New samples arriving during busy must not disturb the snapshot.
        do_reset();
        push_samples(16'h4000);
        accept_update(16'h4000);
        sample_valid = 1'b1;
        xn = 16'h7FFF;
        wait_done(n);
        sample_valid = 1'b0;
        chk("sv_busy_latency", n, 16);
        chk("sv_busy_c3", coef[3], 16'h0020);
        chk("sv_busy_c14", coef[14], 16'h0020);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lms_coef_update.md
LMS_COEF_UPDATE -- requirements
Module: lms_coef_update

Interface
REQ-001 Parameter NTAPS, 15, number of adapted taps.
REQ-002 Parameter MU_SHIFT, 8, step size as arithmetic right shift, range 0..15.
REQ-003 Parameter CENTER, 7, tap index holding the reset value 0x7FFF.
REQ-004 Port clk  input  1  rising-edge clock, single domain.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port xn  input  16  signed Q1.15 equalizer input sample.
REQ-007 Port sample_valid  input  1  shift xn into sample history this cycle.
REQ-008 Port err  input  16  signed Q1.15 error (desired minus yn).
REQ-009 Port err_valid  input  1  request one coefficient update using err.
REQ-010 Port freeze  input  1  when high, ignore err_valid (no drop count).
REQ-011 Port load_en  input  1  direct coefficient write request.
REQ-012 Port load_idx  input  4  coefficient index for load.
REQ-013 Port load_data  input  16  signed coefficient value for load.
REQ-014 Port coef  output  16x16  signed coefficient array, coef[0..15], drives filter coef port.
REQ-015 Port busy  output  1  high from acceptance through DONE.
REQ-016 Port upd_done  output  1  one-cycle pulse when update completes.
REQ-017 Port err_drop  output  1  one-cycle pulse when err_valid is rejected due to busy.
REQ-018 Port drop_cnt  output  8  saturating count of dropped requests.

Function
REQ-019 History hist[0..NTAPS-1] SHALL shift on sample_valid: hist[0]<=xn, hist[i]<=hist[i-1]; shifting continues regardless of FSM state.
REQ-020 FSM states IDLE, UPDATE, DONE; IDLE->UPDATE on err_valid & ~freeze; UPDATE->DONE after idx=NTAPS-1 write; DONE->IDLE unconditionally.
REQ-021 On acceptance, err and hist SHALL be snapshotted; UPDATE uses only snapshots, so sample_valid during busy does not affect the update.
REQ-022 UPDATE SHALL process one tap per cycle, idx 0..NTAPS-1: coef[idx] <= sat16(coef[idx] + ((err_s*hist_s[idx]) >>> (15+MU_SHIFT))).
REQ-023 Product 32-bit signed; shift arithmetic (floor); sum 17-bit; saturate to [0x8000, 0x7FFF].
REQ-024 Latency: err_valid sampled at edge E; tap i written at edge E+1+i; upd_done high during the cycle after edge E+NTAPS; busy high for NTAPS+1 cycles.
REQ-025 err_valid & ~freeze while busy SHALL pulse err_drop the same cycle and increment drop_cnt, which saturates at 255.
REQ-026 load_en SHALL write coef[load_idx]<=load_data only in IDLE; it is ignored while busy and for load_idx >= NTAPS.
REQ-027 load_en and accepted err_valid in the same IDLE cycle: the load is applied first, and the update uses the loaded value.
REQ-028 coef[15] SHALL be constant 0.
REQ-029 coef SHALL be registered and change only on load or UPDATE writes.

Reset
REQ-030 rst SHALL set coef[CENTER]=0x7FFF, all other coef=0, hist and snapshots=0, state IDLE, busy=0, upd_done=0, err_drop=0, drop_cnt=0.
REQ-031 rst asserted mid-UPDATE SHALL abort the update, apply REQ-030 at that edge, and produce no upd_done pulse.

Verification
REQ-032 Reset: coef[7]=0x7FFF, coef[others]=0, busy=0, drop_cnt=0.
REQ-033 15 samples 0x4000, err=0x4000 -> each tap +0x0020, coef[7] stays 0x7FFF (saturated), upd_done exactly 16 cycles after acceptance.
REQ-034 15 samples 0x8000, err=0x7FFF -> each tap -0x0080 (0xFF80), coef[7]=0x7F7F.
REQ-035 load coef[0]=0x8010, then the REQ-034 stimulus -> coef[0]=0x8000 (negative saturation).
REQ-036 err_valid 3 times during busy -> 3 err_drop pulses, drop_cnt=3; freeze=1 with err_valid -> no update and no drop; 300 drops -> drop_cnt=255.
REQ-037 rst at idx=5 mid-update -> all coef return to reset values, no upd_done; sample_valid during busy leaves the update results unchanged.
